// File: rtl/fpga_cmd_decoder.sv
// fpga_cmd_decoder
//   SPI configuration receiver. The ARM SPI is sampled in the pck0 domain.
//   The block decodes configuration commands and shifts a readback word out
//   on miso. A change of major mode is break-before-make: the mode muxes are
//   forced to "everything off" (all ones) for GUARD_CYCLES cycles before the
//   new mode is applied.
//
// Ports
//   pck0          system clock, rising edge
//   reset         synchronous, active-high reset
//   spck/mosi/ncs asynchronous SPI inputs (ncs active low, MSB first)
//   miso          readback data, 0 while ncs is high
//   conf_word     active configuration word
//   major_mode    output mux select, all ones = everything off
//   divisor       clock divisor register
//   mode_busy     high while a mode switch is in progress
//   mode_changed  one-cycle pulse when a new mode is applied
//   frame_err     one-cycle pulse when a frame of the wrong length ends
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation, major_mode follows conf_word
// GUARD | mode change pending, muxes forced off, staged word waiting
module fpga_cmd_decoder #(
    parameter int FRAME_BITS   = 16,
    parameter int CMD_BITS     = 4,
    parameter int CONF_BITS    = 8,
    parameter int MODE_BITS    = 3,
    parameter int GUARD_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 pck0,
    input  logic                 reset,
    input  logic                 spck,
    input  logic                 mosi,
    input  logic                 ncs,
    output logic                 miso,
    output logic [CONF_BITS-1:0] conf_word,
    output logic [MODE_BITS-1:0] major_mode,
    output logic [7:0]           divisor,
    output logic                 mode_busy,
    output logic                 mode_changed,
    output logic                 frame_err
);

    localparam int CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);
    localparam int PAD    = FRAME_BITS - CONF_BITS - 2;
    localparam logic [CONF_BITS-1:0] CONF_RESET =
        {{MODE_BITS{1'b1}}, {(CONF_BITS - MODE_BITS){1'b0}}};

    typedef enum logic [0:0] {RUN, GUARD} state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  spck_sync_q, mosi_sync_q, ncs_sync_q;
    logic                    spck_prev_q, ncs_prev_q;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   rb_q, rb_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GCNT_W-1:0]       guard_cnt_q;
    logic [CONF_BITS-1:0]    conf_q, stage_q;
    logic [MODE_BITS-1:0]    major_q;
    logic [7:0]              div_q;
    logic                    busy_q, changed_q, err_q, last_err_q;

    logic spck_s, mosi_s, ncs_s;
    logic spck_rise, spck_fall, ncs_rise, ncs_fall;
    logic frame_ok, set_conf, set_div;
    logic [CMD_BITS-1:0]  cmd;
    logic [CONF_BITS-1:0] payload;
    logic [MODE_BITS-1:0] new_mode, act_mode;

    assign spck_s    = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_prev_q;
    assign spck_fall = ~spck_s & spck_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    assign frame_ok  = (bit_cnt_q == CNT_W'(FRAME_BITS));
    assign cmd       = shift_q[FRAME_BITS-1 -: CMD_BITS];
    assign payload   = shift_q[CONF_BITS-1:0];
    assign new_mode  = payload[CONF_BITS-1 -: MODE_BITS];
    assign act_mode  = conf_q[CONF_BITS-1 -: MODE_BITS];
    assign set_conf  = ncs_rise && frame_ok && (cmd == CMD_BITS'(1));
    assign set_div   = ncs_rise && frame_ok && (cmd == CMD_BITS'(2));

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rb_d      = rb_q;
        if (ncs_rise) begin
            bit_cnt_d = '0;
        end else if (spck_rise && !ncs_s) begin
            shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
            // Saturate one past a full frame so long frames stay detectable.
            if (bit_cnt_q != CNT_W'(FRAME_BITS + 1))
                bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (ncs_fall)
            rb_d = {busy_q, last_err_q, {PAD{1'b0}}, conf_q};
        else if (spck_fall && !ncs_s)
            rb_d = {rb_q[FRAME_BITS-2:0], 1'b0};
    end

    always_ff @(posedge pck0) begin
        if (reset) begin
            state_q     <= RUN;
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            shift_q     <= '0;
            rb_q        <= '0;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            conf_q      <= CONF_RESET;
            stage_q     <= CONF_RESET;
            major_q     <= '1;
            div_q       <= '0;
            busy_q      <= 1'b0;
            changed_q   <= 1'b0;
            err_q       <= 1'b0;
            last_err_q  <= 1'b0;
        end else begin
            spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            spck_prev_q <= spck_s;
            ncs_prev_q  <= ncs_s;
            shift_q     <= shift_d;
            rb_q        <= rb_d;
            bit_cnt_q   <= bit_cnt_d;
            err_q       <= ncs_rise && !frame_ok;
            changed_q   <= 1'b0;
            if (ncs_rise)
                last_err_q <= !frame_ok;
            if (set_div)
                div_q <= shift_q[7:0];
            case (state_q)
                RUN: begin
                    if (set_conf) begin
                        if (new_mode != act_mode) begin
                            stage_q     <= payload;
                            guard_cnt_q <= GCNT_W'(GUARD_CYCLES - 1);
                            major_q     <= '1;
                            busy_q      <= 1'b1;
                            state_q     <= GUARD;
                        end else begin
                            conf_q <= payload;
                        end
                    end
                end
                GUARD: begin
                    // Any new config restarts the guard, even one that
                    // matches the active mode: the muxes are already off.
                    if (set_conf) begin
                        stage_q     <= payload;
                        guard_cnt_q <= GCNT_W'(GUARD_CYCLES - 1);
                    end else if (guard_cnt_q == '0) begin
                        conf_q    <= stage_q;
                        major_q   <= stage_q[CONF_BITS-1 -: MODE_BITS];
                        changed_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= RUN;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign miso         = ~ncs_s & rb_q[FRAME_BITS-1];
    assign conf_word    = conf_q;
    assign major_mode   = major_q;
    assign divisor      = div_q;
    assign mode_busy    = busy_q;
    assign mode_changed = changed_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_fpga_cmd_decoder.sv
// Bench for fpga_cmd_decoder. The guard is made longer than one SPI frame
// so that a second frame can be decoded while the first guard is running.
module tb_fpga_cmd_decoder;
    localparam int G = 160;
    localparam int H = 4;

    logic pck0 = 1'b0, reset = 1'b1, spck = 1'b0, mosi = 1'b0, ncs = 1'b1;
    logic       miso, mode_busy, mode_changed, frame_err;
    logic [7:0] conf_word, divisor;
    logic [2:0] major_mode;

    fpga_cmd_decoder #(.FRAME_BITS(16), .CMD_BITS(4), .CONF_BITS(8), .MODE_BITS(3),
                       .GUARD_CYCLES(G), .SYNC_STAGES(2)) dut (
        .pck0(pck0), .reset(reset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .miso(miso), .conf_word(conf_word), .major_mode(major_mode),
        .divisor(divisor), .mode_busy(mode_busy), .mode_changed(mode_changed),
        .frame_err(frame_err));

    always #5 pck0 = ~pck0;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge pck0) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor
    int mc_cnt = 0, err_cnt = 0, viol = 0, busy_wins = 0;
    int busy_run = 0, last_busy_len = 0, ones_run = 0, last_ones_len = 0;
    logic mc_prev = 0, err_prev = 0, busy_prev = 0;
    logic [7:0] conf_prev = 8'h00;
    always @(negedge pck0) begin
        if (mode_changed && mc_prev) viol++;
        if (frame_err && err_prev) viol++;
        if (mode_changed) mc_cnt++;
        if (frame_err) err_cnt++;
        if (mode_busy && !busy_prev) busy_wins++;
        if (mode_busy) busy_run++;
        else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end
        if (major_mode == 3'b111) ones_run++;
        else if (ones_run != 0) begin last_ones_len = ones_run; ones_run = 0; end
        if (mode_busy && major_mode != 3'b111) viol++;
        if (mode_busy && busy_prev && conf_word != conf_prev) viol++;
        mc_prev = mode_changed; err_prev = frame_err;
        busy_prev = mode_busy; conf_prev = conf_word;
    end

    // Reference model, event level: each frame end at bench cycle r.
    logic [7:0] m_conf, m_stage, m_div;
    bit m_pend, m_lerr;
    int m_gend, exp_mc = 0, exp_err = 0;

    task automatic m_reset();
        m_conf = 8'hE0; m_stage = 8'hE0; m_div = 8'h00; m_pend = 0; m_lerr = 0;
    endtask

    task automatic retire(input int t);
        if (m_pend && t >= m_gend) begin
            m_conf = m_stage; m_pend = 0; exp_mc++;
        end
    endtask

    task automatic m_decode(input logic [16:0] d, input int n, input int r);
        retire(r);
        if (n != 16) begin
            exp_err++; m_lerr = 1;
        end else begin
            m_lerr = 0;
            if (d[15:12] == 4'h1) begin
                if (m_pend || d[7:5] != m_conf[7:5]) begin
                    m_pend = 1; m_stage = d[7:0]; m_gend = r + G;
                end else begin
                    m_conf = d[7:0];
                end
            end else if (d[15:12] == 4'h2) begin
                m_div = d[7:0];
            end
        end
    endtask

    task automatic clock_bits(input logic [16:0] d, input int first, input int last,
                              inout logic [15:0] rb_obs);
        for (int i = first; i < last; i++) begin
            mosi = d[last - 1 - i];
            if (i < 16) rb_obs[15 - i] = miso;
            spck = 1'b1;
            repeat (H) @(posedge pck0);
            #1 spck = 1'b0;
            repeat (H) @(posedge pck0);
            #1;
        end
    endtask

    task automatic send_frame(input logic [16:0] d, input int n, input int gap, output int r);
        logic [15:0] rb_obs, exp_rb;
        rb_obs = '0;
        @(posedge pck0); #1;
        ncs = 1'b0;
        retire(cyc);
        exp_rb = {m_pend, m_lerr, 6'b0, m_conf};
        repeat (6) @(posedge pck0);
        #1;
        clock_bits(d, 0, n, rb_obs);
        ncs = 1'b1;
        r = cyc;
        m_decode(d, n, r);
        if (n == 16) check_eq("readback", {16'h0, rb_obs}, {16'h0, exp_rb});
        repeat (gap) @(posedge pck0);
    endtask

    task automatic check_outs(input string tag);
        check_eq({tag, "_conf"}, conf_word, m_conf);
        check_eq({tag, "_major"}, major_mode, m_pend ? 3'b111 : m_conf[7:5]);
        check_eq({tag, "_div"}, divisor, m_div);
        check_eq({tag, "_busy"}, mode_busy, m_pend);
        check_eq({tag, "_mc_cnt"}, mc_cnt, exp_mc);
        check_eq({tag, "_err_cnt"}, err_cnt, exp_err);
    endtask

    task automatic settle(input string tag);
        repeat (G + 40) @(posedge pck0);
        #1;
        retire(cyc);
        check_outs(tag);
    endtask

    initial begin
        int r, r1, r2, wins0, n, gap, sel;
        logic [16:0] d;
        logic [15:0] dummy;

        m_reset();
        repeat (5) @(posedge pck0);
        #1 reset = 1'b0;
        repeat (20) @(posedge pck0);
        #1;
        check_outs("idle");
        check_eq("idle_miso", miso, 1'b0);

        send_frame(17'h01047, 16, 0, r);
        settle("first_mode");
        check_eq("first_guard_len", last_busy_len, G);

        wins0 = busy_wins;
        send_frame(17'h01045, 16, 10, r);
        check_eq("same_mode_conf", conf_word, m_conf);
        check_eq("same_mode_noguard", busy_wins, wins0);
        send_frame(17'h02021, 16, 10, r);
        check_eq("divisor", divisor, m_div);

        send_frame(17'h01047 >> 1, 15, 10, r);
        send_frame(17'h02088, 17, 10, r);
        check_outs("bad_len");
        send_frame(17'h03000, 16, 10, r);

        send_frame(17'h01020, 16, 0, r);
        settle("single_guard");
        check_eq("single_busy_len", last_busy_len, G);
        check_eq("single_off_len", last_ones_len, G);

        send_frame(17'h01060, 16, 4, r1);
        send_frame(17'h01020, 16, 0, r2);
        settle("restart");
        check_eq("restart_busy_len", last_busy_len, r2 - r1 + G);
        check_eq("restart_off_len", last_ones_len, r2 - r1 + G);

        for (int k = 0; k < 30; k++) begin
            n = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 15 : 17) : 16;
            sel = $urandom_range(0, 19);
            d = 17'($urandom);
            if (sel < 10) d[15:12] = 4'h1;
            else if (sel < 15) d[15:12] = 4'h2;
            sel = $urandom_range(0, 2);
            gap = (sel == 0) ? $urandom_range(0, 8) :
                  (sel == 1) ? $urandom_range(40, 100) : $urandom_range(200, 260);
            send_frame(d, n, gap, r);
        end
        settle("random");

        // Reset in the middle of a guard and of a partial frame.
        d = {5'h01, 4'h0, m_conf[7:5] ^ 3'b101, 5'h0A};
        send_frame(d, 16, 0, r);
        @(posedge pck0); #1;
        ncs = 1'b0;
        repeat (6) @(posedge pck0);
        #1;
        dummy = '0;
        clock_bits(17'h1FFFF, 0, 5, dummy);
        check_eq("pre_reset_busy", mode_busy, 1'b1);
        reset = 1'b1;
        @(posedge pck0); #1;
        m_reset();
        check_outs("reset_mid");
        check_eq("reset_miso", miso, 1'b0);
        @(posedge pck0); #1;
        reset = 1'b0;
        repeat (6) @(posedge pck0);
        #1;
        clock_bits(17'h1FFFF, 0, 5, dummy);
        ncs = 1'b1;
        m_decode(17'h0, 5, cyc);
        settle("partial_after_reset");

        check_eq("monitor_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
